// File: rtl/mips_controller_pkg.sv
// Shared encodings for the multicycle MIPS control unit: states, opcodes,
// funct codes, aluop and alucontrol values.
package mips_defs;

  typedef enum logic [3:0] {
    S_FETCH1  = 4'd0,
    S_FETCH2  = 4'd1,
    S_FETCH3  = 4'd2,
    S_FETCH4  = 4'd3,
    S_DECODE  = 4'd4,
    S_MEMADR  = 4'd5,
    S_LBRD    = 4'd6,
    S_LBWR    = 4'd7,
    S_SBWR    = 4'd8,
    S_RTYPEEX = 4'd9,
    S_RTYPEWR = 4'd10,
    S_BEQEX   = 4'd11,
    S_JEX     = 4'd12,
    S_ADDIEX  = 4'd13,
    S_ADDIWR  = 4'd14
  } state_t;

  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mips_controller_alu_decoder.sv
// ALU operation decode from aluop and the R-type funct field. Combinational.
module alu_decoder
  import mips_defs::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  // Fixed ops for 00/01, funct lookup for 10; anything unknown falls back to add
  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB:   alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default:     alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_controller.sv
// Moore control FSM for the 8-bit multicycle MIPS datapath: four byte fetch
// cycles, decode, then per-class execute/writeback states.
module mips_controller
  import mips_defs::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       memread,
  output logic       memwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       iord,
  output logic [3:0] irwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic [1:0] pcsource,
  output logic       pcen,
  output logic [2:0] alucontrol
);

  state_t     state;
  state_t     dstate;
  logic [1:0] aluop;
  logic       pcwrite;
  logic       branch;
  logic       rd_raw, wr_raw, rw_raw;
  logic [3:0] ir_raw;

  // State register and transitions; op is consulted only in DECODE and MEMADR
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH1;
    end else begin
      case (state)
        S_FETCH1:  state <= S_FETCH2;
        S_FETCH2:  state <= S_FETCH3;
        S_FETCH3:  state <= S_FETCH4;
        S_FETCH4:  state <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LB, OP_SB: state <= S_MEMADR;
            OP_RTYPE:     state <= S_RTYPEEX;
            OP_BEQ:       state <= S_BEQEX;
            OP_J:         state <= S_JEX;
            OP_ADDI:      state <= S_ADDIEX;
            default:      state <= S_FETCH1;  // illegal op retires as a NOP
          endcase
        end
        S_MEMADR:  state <= (op == OP_LB) ? S_LBRD : S_SBWR;
        S_LBRD:    state <= S_LBWR;
        S_RTYPEEX: state <= S_RTYPEWR;
        S_ADDIEX:  state <= S_ADDIWR;
        default:   state <= S_FETCH1;
      endcase
    end
  end

  // While reset is high the outputs present FETCH1 so the datapath sees a
  // clean, enable-free image even if the register still holds an old state
  assign dstate = reset ? S_FETCH1 : state;

  // Moore output decode from the (reset-overridden) state
  always_comb begin
    rd_raw   = 1'b0;
    wr_raw   = 1'b0;
    rw_raw   = 1'b0;
    ir_raw   = 4'b0000;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    iord     = 1'b0;
    memtoreg = 1'b0;
    regdst   = 1'b0;
    pcsource = 2'b00;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    aluop    = ALUOP_ADD;
    case (dstate)
      S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4: begin
        rd_raw  = 1'b1;
        ir_raw  = 4'b0001 << dstate[1:0];
        alusrcb = 2'b01;
        pcwrite = 1'b1;
      end
      S_DECODE:  alusrcb = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_LBRD: begin
        rd_raw = 1'b1;
        iord   = 1'b1;
      end
      S_LBWR: begin
        rw_raw   = 1'b1;
        memtoreg = 1'b1;
      end
      S_SBWR: begin
        wr_raw = 1'b1;
        iord   = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWR: begin
        rw_raw = 1'b1;
        regdst = 1'b1;
      end
      S_BEQEX: begin
        alusrca  = 1'b1;
        aluop    = ALUOP_SUB;
        branch   = 1'b1;
        pcsource = 2'b01;
      end
      S_JEX: begin
        pcwrite  = 1'b1;
        pcsource = 2'b10;
      end
      S_ADDIWR:  rw_raw = 1'b1;
      default: ;
    endcase
  end

  // Strobes and enables are gated by reset so an aborted instruction leaves no trace
  always_comb begin
    memread  = rd_raw & ~reset;
    memwrite = wr_raw & ~reset;
    regwrite = rw_raw & ~reset;
    irwrite  = reset ? 4'b0000 : ir_raw;
    pcen     = (pcwrite | (branch & zero)) & ~reset;
  end

  alu_decoder u_aludec (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

endmodule

// File: tb/tb_mips_controller.sv
// Bench for mips_controller: an instruction-level model (cycle index within
// the current instruction) predicts every output each cycle; directed runs
// add literal checks on cycle counts and key control values.
module tb_mips_controller;

  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       iord;
    logic [3:0] irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic [1:0] pcsource;
    logic       pcen;
    logic [2:0] alucontrol;
  } outs_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [5:0] op = 6'b000000;
  logic [5:0] funct = 6'b101010;
  logic zero = 1'b0;
  outs_t cur;

  int checks = 0;
  int passed = 0;

  mips_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .memread    (cur.memread),
    .memwrite   (cur.memwrite),
    .alusrca    (cur.alusrca),
    .alusrcb    (cur.alusrcb),
    .iord       (cur.iord),
    .irwrite    (cur.irwrite),
    .memtoreg   (cur.memtoreg),
    .regdst     (cur.regdst),
    .regwrite   (cur.regwrite),
    .pcsource   (cur.pcsource),
    .pcen       (cur.pcen),
    .alucontrol (cur.alucontrol)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Instruction length in cycles, straight from the per-class CPI table
  function automatic int ilen(input logic [5:0] o);
    case (o)
      6'b100000: return 8;
      6'b101000: return 7;
      6'b000000: return 7;
      6'b001000: return 7;
      6'b000100: return 6;
      6'b000010: return 6;
      default:   return 5;
    endcase
  endfunction

  function automatic logic [2:0] fdec(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Expected outputs for cycle k of an instruction with the given op
  function automatic outs_t expect_at(input logic [5:0] o, input logic [5:0] f,
                                      input logic z, input int k, input logic r);
    outs_t e;
    e = '0;
    e.alucontrol = 3'b010;
    if (k < 4) begin
      e.memread = 1'b1;
      e.irwrite = 4'(1 << k);
      e.alusrcb = 2'b01;
      e.pcen    = 1'b1;
    end else if (k == 4) begin
      e.alusrcb = 2'b11;
    end else begin
      case (o)
        6'b100000, 6'b101000: begin
          if (k == 5) begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
          else if (o == 6'b100000 && k == 6) begin e.memread = 1'b1; e.iord = 1'b1; end
          else if (o == 6'b100000 && k == 7) begin e.regwrite = 1'b1; e.memtoreg = 1'b1; end
          else if (o == 6'b101000 && k == 6) begin e.memwrite = 1'b1; e.iord = 1'b1; end
        end
        6'b000000: begin
          if (k == 5) begin e.alusrca = 1'b1; e.alucontrol = fdec(f); end
          else begin e.regwrite = 1'b1; e.regdst = 1'b1; end
        end
        6'b000100: begin
          e.alusrca = 1'b1; e.alucontrol = 3'b110; e.pcsource = 2'b01; e.pcen = z;
        end
        6'b000010: begin
          e.pcen = 1'b1; e.pcsource = 2'b10;
        end
        6'b001000: begin
          if (k == 5) begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
          else e.regwrite = 1'b1;
        end
        default: ;
      endcase
    end
    if (r) begin
      e.memread = 1'b0; e.memwrite = 1'b0; e.regwrite = 1'b0; e.irwrite = 4'b0000; e.pcen = 1'b0;
    end
    return e;
  endfunction

  // Model: advance the in-instruction cycle index at each edge, then compare
  int  mk = 0;
  bit  armed = 0;
  always @(posedge clk) begin
    if (reset) begin
      mk = 0;
      armed = 1;
    end else if (armed) begin
      mk = (mk + 1 == ilen(op)) ? 0 : mk + 1;
    end
    #1;
    if (armed) begin
      chk("model", 32'(cur), 32'(expect_at(op, funct, zero, mk, reset)));
      chk("ir_onehot", 32'($countones(cur.irwrite) <= 1), 32'd1);
      chk("rd_wr_excl", 32'(cur.memread & cur.memwrite), 32'd0);
    end
  end

  outs_t tr [0:19];

  // Run one instruction starting in FETCH1; record outputs per cycle and
  // return the measured cycle count until the next FETCH1
  task automatic run(input logic [5:0] o, input logic [5:0] f, input logic z,
                     input int explen, input string name);
    int c;
    op = o; funct = f; zero = z;
    #1;
    tr[0] = cur;
    c = 0;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk); #1;
      c++;
      if (cur.irwrite == 4'b0001) break;
      tr[c] = cur;
    end
    chk({name, "_len"}, 32'(c), 32'(explen));
  endtask

  initial begin
    int wsum;
    // Reset held 3 cycles with an R-type on the op lines
    op = 6'b000000; funct = 6'b101010; reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("rst_wen", 32'({cur.memread, cur.memwrite, cur.regwrite, cur.irwrite, cur.pcen}), 32'd0);
    end
    chk("rst_alusrcb", 32'(cur.alusrcb), 32'd1);
    reset = 1'b0;

    // R-type slt: first cycles are the fetch sequence
    run(6'b000000, 6'b101010, 1'b0, 7, "rtype_slt");
    chk("f1_ir", 32'(tr[0].irwrite), 32'h1);
    chk("f2_ir", 32'(tr[1].irwrite), 32'h2);
    chk("f3_ir", 32'(tr[2].irwrite), 32'h4);
    chk("f4_ir", 32'(tr[3].irwrite), 32'h8);
    chk("fetch_pcen", 32'({tr[0].pcen, tr[1].pcen, tr[2].pcen, tr[3].pcen}), 32'hF);
    chk("rtex_alu", 32'(tr[5].alucontrol), 32'b111);
    chk("rtwr_rw_rd", 32'({tr[6].regwrite, tr[6].regdst}), 32'b11);

    run(6'b000000, 6'b100010, 1'b0, 7, "rtype_sub");
    chk("rtex_sub", 32'(tr[5].alucontrol), 32'b110);
    run(6'b000000, 6'b100100, 1'b0, 7, "rtype_and");
    run(6'b000000, 6'b100101, 1'b0, 7, "rtype_or");
    run(6'b000000, 6'b111000, 1'b0, 7, "rtype_unk");
    chk("rtex_unk", 32'(tr[5].alucontrol), 32'b010);

    run(6'b100000, 6'b000000, 1'b0, 8, "lb");
    chk("memadr_srcb", 32'(tr[5].alusrcb), 32'b10);
    chk("lbrd", 32'({tr[6].memread, tr[6].iord}), 32'b11);
    chk("lbwr", 32'({tr[7].regwrite, tr[7].memtoreg}), 32'b11);

    run(6'b101000, 6'b000000, 1'b0, 7, "sb");
    chk("sbwr", 32'({tr[6].memwrite, tr[6].iord, tr[6].memread}), 32'b110);

    run(6'b000100, 6'b000000, 1'b1, 6, "beq_taken");
    chk("beq_t", 32'({tr[5].pcen, tr[5].pcsource, tr[5].alucontrol}), 32'b1_01_110);
    run(6'b000100, 6'b000000, 1'b0, 6, "beq_nt");
    chk("beq_nt_pcen", 32'(tr[5].pcen), 32'd0);

    run(6'b001000, 6'b000000, 1'b0, 7, "addi");
    chk("addiwr", 32'({tr[6].regwrite, tr[6].regdst, tr[6].memtoreg}), 32'b100);

    run(6'b000010, 6'b000000, 1'b0, 6, "j");
    chk("jex", 32'({tr[5].pcen, tr[5].pcsource}), 32'b1_10);

    run(6'b111111, 6'b000000, 1'b0, 5, "illegal");
    chk("illegal_dec_wen", 32'({tr[4].memread, tr[4].memwrite, tr[4].regwrite, tr[4].irwrite, tr[4].pcen}), 32'd0);

    // Reset pulsed while an LB is in LBRD
    op = 6'b100000;
    for (int i = 0; i < 6; i++) @(negedge clk);
    #1;
    chk("abort_in_lbrd", 32'({cur.memread, cur.iord}), 32'b11);
    reset = 1'b1;
    #1;
    chk("abort_masked", 32'({cur.memread, cur.regwrite, cur.irwrite}), 32'd0);
    wsum = 0;
    @(negedge clk); #1;
    wsum += cur.regwrite;
    chk("abort_next_f1", 32'(cur.alusrcb), 32'b01);
    reset = 1'b0;
    #1;
    chk("abort_f1_ir", 32'(cur.irwrite), 32'h1);
    wsum += cur.regwrite;
    @(negedge clk); #1;
    wsum += cur.regwrite;
    chk("abort_f2_ir", 32'(cur.irwrite), 32'h2);
    chk("abort_no_rw", 32'(wsum), 32'd0);

    @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got %0d/%0d", passed, checks);
    $fatal(1);
  end

endmodule

// File: doc/mips_controller.md
# mips_controller

Multicycle control unit for the 8-bit MIPS datapath. Decodes opcode and funct from the assembled 32-bit instruction, sequences the four byte-wide fetch cycles, and drives every datapath select and enable. It also drives the memory read and write strobes. It is a Moore FSM with one combinational ALU-decode sub-block. It sits beside the datapath in the top-level processor, between instruction fields, the zero flag and external memory.

## Interface
- No parameters; all encodings are fixed constants in the shared package.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- op  in  6  instr[31:26] from the datapath.
- funct  in  6  instr[5:0] from the datapath.
- zero  in  1  ALU-result-is-zero flag from the datapath.
- memread  out  1  memory read strobe.
- memwrite  out  1  memory write strobe.
- alusrca  out  1  ALU A select: 0 = PC, 1 = register A.
- alusrcb  out  2  ALU B select: 00 = register B, 01 = constant 1, 10 = imm[7:0], 11 = imm[7:0] << 2.
- iord  out  1  address select: 0 = PC, 1 = ALUOut.
- irwrite  out  4  one-hot instruction-byte load enable.
- memtoreg  out  1  register write-data select: 0 = ALUOut, 1 = memory data.
- regdst  out  1  register write-address select: 0 = rt, 1 = rd.
- regwrite  out  1  register file write enable.
- pcsource  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- pcen  out  1  PC load enable, equal to pcwrite | (branch & zero).
- alucontrol  out  3  ALU operation: 010 = add, 110 = sub, 000 = and, 001 = or, 111 = slt.

## Operation
- States (4-bit encoding): FETCH1–FETCH4, DECODE, MEMADR, LBRD, LBWR, SBWR, RTYPEEX, RTYPEWR, BEQEX, JEX, ADDIEX, ADDIWR.
- Opcodes: LB 100000, SB 101000, RTYPE 000000, BEQ 000100, J 000010, ADDI 001000.
- Outputs not listed for a state are 0.
- FETCHn (n = 1..4): memread, irwrite = 1 << (n-1), alusrcb 01, pcwrite, aluop 00.
- DECODE: alusrcb 11, aluop 00 (branch target precomputed).
- MEMADR and ADDIEX: alusrca 1, alusrcb 10, aluop 00.
- LBRD: memread, iord. LBWR: regwrite, memtoreg. SBWR: memwrite, iord.
- RTYPEEX: alusrca 1, alusrcb 00, aluop 10. RTYPEWR: regwrite, regdst.
- BEQEX: alusrca 1, alusrcb 00, aluop 01, branch, pcsource 01.
- JEX: pcwrite, pcsource 10. ADDIWR: regwrite.
- FETCH1 → FETCH2 → FETCH3 → FETCH4 → DECODE.
- DECODE dispatches on op: LB or SB → MEMADR; RTYPE → RTYPEEX; BEQ → BEQEX; J → JEX; ADDI → ADDIEX.
- An unrecognised op in DECODE goes to FETCH1. The instruction executes as a NOP and no write enable is raised.
- MEMADR → LBRD if op = LB, otherwise SBWR.
- LBRD → LBWR → FETCH1. RTYPEEX → RTYPEWR → FETCH1. ADDIEX → ADDIWR → FETCH1.
- SBWR, BEQEX and JEX → FETCH1.
- ALU decode, by aluop:
  - 00 → add (010); 01 → sub (110).
  - 10 with funct 100000 → add (010); 100010 → sub (110); 100100 → and (000); 100101 → or (001); 101010 → slt (111).
  - 10 with any other funct → add (010).
  - aluop 11 is unused and decodes as add (010).

## Timing
- Outputs are decoded from the state register only; there is no combinational path from op or funct to outputs other than alucontrol.
- pcen additionally depends combinationally on zero, in BEQEX only.
- Reset: state ← FETCH1 at the reset edge.
- While reset = 1, memread, memwrite, regwrite, irwrite and pcen are forced 0. All other outputs show their FETCH1 values.
- The first cycle after reset deasserts is FETCH1.
- Reset asserted mid-instruction aborts it at the next edge. No partial register or memory write occurs in the reset cycle.
- Cycles per instruction: LB 8, SB 7, RTYPE 7, ADDI 7, BEQ 6, J 6, illegal 5.
- irwrite is never multi-hot.
- memread and memwrite are never high together.

## Structure
- Shared package `mips_defs` holds: the state encodings, the opcode and funct constants, the aluop codes (00 add, 01 sub, 10 funct) and the alucontrol codes.
- Sub-module `alu_decoder` (aluop, funct → alucontrol) is purely combinational.
- The top level contains a single state register, the next-state logic and the output decode.

## Test plan
- Reset held for 3 cycles with op = RTYPE: all write enables stay 0. After release, the state sequence is FETCH1..FETCH4, with irwrite 0001, 0010, 0100, 1000 and pcen = 1 in each cycle.
- op = 000000, funct = 101010: RTYPEEX shows alucontrol 111; RTYPEWR shows regwrite = 1, regdst = 1; back in FETCH1 at cycle 8.
- op = LB: MEMADR alusrcb 10; LBRD memread = 1, iord = 1; LBWR regwrite = 1, memtoreg = 1; total 8 cycles. op = SB: SBWR memwrite = 1, iord = 1; total 7 cycles.
- op = BEQ with zero = 1: pcen = 1, pcsource 01, alucontrol 110 in BEQEX. With zero = 0: pcen = 0. Both cases return to FETCH1.
- op = J: JEX pcen = 1, pcsource 10. Then op = 111111: DECODE → FETCH1 with no write enable raised.
- Reset pulsed during LBRD: the next state is FETCH1, and regwrite is never asserted for the aborted instruction.
